// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/strobe inputs and display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       pause_p;
    logic       adj;
    logic       sel;
    logic       tick_1hz;
    logic       tick_2hz;
    logic [2:0] min1;
    logic [3:0] min2;
    logic [2:0] sec1;
    logic [3:0] sec2;
    logic       blank_min;
    logic       blank_sec;
    logic [1:0] mode;

    modport master (
        output pause_p, adj, sel, tick_1hz, tick_2hz,
        input  min1, min2, sec1, sec2, blank_min, blank_sec, mode
    );

    modport slave (
        input  pause_p, adj, sel, tick_1hz, tick_2hz,
        output min1, min2, sec1, sec2, blank_min, blank_sec, mode
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - RUN/PAUSE/ADJUST mode controller and MM:SS BCD time-keeping core
module stopwatch_ctrl #(
    parameter bit START_PAUSED = 1'b0,
    parameter bit BLINK_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSE  = 2'b01,
        ST_ADJUST = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic       pause_q, pause_d;
    logic       phase_q, phase_d;
    logic [2:0] min1_q, min1_d, sec1_q, sec1_d;
    logic [3:0] min2_q, min2_d, sec2_q, sec2_d;
    logic       blank_min_q, blank_min_d;
    logic       blank_sec_q, blank_sec_d;
    logic [7:0] sec_inc, min_inc;

    // Returns {carry_out, tens, ones} for a 00-59 BCD field advanced by one.
    function automatic logic [7:0] inc59(input logic [2:0] tens, input logic [3:0] ones);
        if (ones != 4'd9)
            inc59 = {1'b0, tens, ones + 4'd1};
        else if (tens != 3'd5)
            inc59 = {1'b0, tens + 3'd1, 4'd0};
        else
            inc59 = {1'b1, 3'd0, 4'd0};
    endfunction

    always_comb begin
        sec_inc = inc59(sec1_q, sec2_q);
        min_inc = inc59(min1_q, min2_q);
        min1_d  = min1_q;
        min2_d  = min2_q;
        sec1_d  = sec1_q;
        sec2_d  = sec2_q;
        phase_d = phase_q;
        pause_d = pause_q ^ bus.pause_p;

        // Actions are decided by the state registered before this edge.
        case (state_q)
            ST_RUN: begin
                if (bus.tick_1hz) begin
                    {sec1_d, sec2_d} = sec_inc[6:0];
                    if (sec_inc[7])
                        {min1_d, min2_d} = min_inc[6:0];
                end
            end
            ST_ADJUST: begin
                if (bus.tick_2hz) begin
                    phase_d = ~phase_q;
                    if (bus.sel)
                        {sec1_d, sec2_d} = sec_inc[6:0];
                    else
                        {min1_d, min2_d} = min_inc[6:0];
                end
            end
            default: ;
        endcase

        if (bus.adj)
            state_d = ST_ADJUST;
        else if (pause_d)
            state_d = ST_PAUSE;
        else
            state_d = ST_RUN;

        if (state_d != ST_ADJUST)
            phase_d = 1'b0;

        blank_min_d = BLINK_EN && (state_d == ST_ADJUST) && !bus.sel && phase_d;
        blank_sec_d = BLINK_EN && (state_d == ST_ADJUST) &&  bus.sel && phase_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= START_PAUSED ? ST_PAUSE : ST_RUN;
            pause_q     <= START_PAUSED;
            phase_q     <= 1'b0;
            min1_q      <= 3'd0;
            min2_q      <= 4'd0;
            sec1_q      <= 3'd0;
            sec2_q      <= 4'd0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_q     <= pause_d;
            phase_q     <= phase_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            sec1_q      <= sec1_d;
            sec2_q      <= sec2_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
        end
    end

    assign bus.min1      = min1_q;
    assign bus.min2      = min2_q;
    assign bus.sec1      = sec1_q;
    assign bus.sec2      = sec2_q;
    assign bus.blank_min = blank_min_q;
    assign bus.blank_sec = blank_sec_q;
    assign bus.mode      = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.START_PAUSED(1'b0), .BLINK_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Time packed as 16'hMMSS BCD.
    function automatic logic [15:0] now();
        return {1'b0, bus.min1, bus.min2, 1'b0, bus.sec1, bus.sec2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_2hz = 1'b1;
            step();
            bus.tick_2hz = 1'b0;
        end
    endtask

    task automatic pulse_pause();
        bus.pause_p = 1'b1;
        step();
        bus.pause_p = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.pause_p  = 1'b0;
        bus.adj      = 1'b0;
        bus.sel      = 1'b0;
        bus.tick_1hz = 1'b0;
        bus.tick_2hz = 1'b0;

        do_reset();
        check_eq("rst_time", now(), 16'h0000);
        check_eq("rst_mode", 16'(bus.mode), 16'h0000);
        check_eq("rst_blank", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);

        tick1(61);
        check_eq("run_61", now(), 16'h0101);
        check_eq("run_mode", 16'(bus.mode), 16'h0000);
        tick2(3);
        check_eq("run_ign_2hz", now(), 16'h0101);

        // Preload 59:59 through ADJUST.
        do_reset();
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        step();
        check_eq("adj_mode", 16'(bus.mode), 16'h0002);
        tick2(59);
        check_eq("adj_min59", now(), 16'h5900);
        tick1(2);
        check_eq("adj_ign_1hz", now(), 16'h5900);
        bus.sel = 1'b1;
        tick2(59);
        check_eq("adj_sec59", now(), 16'h5959);
        bus.adj = 1'b0;
        step();
        check_eq("adj_exit_mode", 16'(bus.mode), 16'h0000);
        tick1(1);
        check_eq("wrap_5959", now(), 16'h0000);

        // Pause holds digits.
        tick1(10);
        check_eq("run_10", now(), 16'h0010);
        pulse_pause();
        check_eq("pause_mode", 16'(bus.mode), 16'h0001);
        tick1(5);
        check_eq("pause_hold", now(), 16'h0010);
        tick2(2);
        check_eq("pause_ign_2hz", now(), 16'h0010);
        pulse_pause();
        check_eq("resume_mode", 16'(bus.mode), 16'h0000);
        tick1(1);
        check_eq("resume_inc", now(), 16'h0011);

        // Seconds-field adjust with blink, no carry into minutes.
        tick1(47);
        check_eq("run_58", now(), 16'h0058);
        bus.adj = 1'b1;
        bus.sel = 1'b1;
        step();
        check_eq("blk_start", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);
        tick2(1);
        check_eq("sadj_59", now(), 16'h0059);
        check_eq("blk_1", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0001);
        tick2(1);
        check_eq("sadj_00", now(), 16'h0000);
        check_eq("blk_2", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);
        tick2(1);
        check_eq("sadj_01", now(), 16'h0001);
        check_eq("blk_3", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0001);
        bus.adj = 1'b0;
        step();
        check_eq("blk_exit", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);
        check_eq("blk_exit_mode", 16'(bus.mode), 16'h0000);
        bus.adj = 1'b1;
        step();
        check_eq("phase_clr", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);
        tick2(1);
        check_eq("phase_clr_inc", now(), 16'h0002);
        check_eq("phase_clr_blk", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0001);
        bus.sel = 1'b0;
        step();
        check_eq("blk_sel_min", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0002);
        pulse_pause();
        check_eq("adj_pause_mode", 16'(bus.mode), 16'h0002);
        bus.adj = 1'b0;
        step();
        check_eq("adj_to_pause", 16'(bus.mode), 16'h0001);
        pulse_pause();
        check_eq("pause_to_run", 16'(bus.mode), 16'h0000);

        // pause_p coincident with tick_1hz in RUN.
        tick1(3);
        check_eq("run_05", now(), 16'h0005);
        bus.pause_p  = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        bus.pause_p  = 1'b0;
        bus.tick_1hz = 1'b0;
        check_eq("coinc_time", now(), 16'h0006);
        check_eq("coinc_mode", 16'(bus.mode), 16'h0001);
        pulse_pause();

        // adj rising with tick_1hz: RUN increment still applies.
        bus.adj      = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        check_eq("adj_rise_inc", now(), 16'h0007);
        check_eq("adj_rise_mode", 16'(bus.mode), 16'h0002);
        bus.adj = 1'b0;
        step();

        // Reset overrides an in-progress adjust strobe.
        do_reset();
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        step();
        tick2(12);
        bus.sel = 1'b1;
        tick2(34);
        check_eq("preload_1234", now(), 16'h1234);
        reset        = 1'b1;
        bus.tick_2hz = 1'b1;
        step();
        reset        = 1'b0;
        bus.tick_2hz = 1'b0;
        check_eq("rst_adj_time", now(), 16'h0000);
        check_eq("rst_adj_blank", {14'd0, bus.blank_min, bus.blank_sec}, 16'h0000);
        check_eq("rst_adj_mode", 16'(bus.mode), 16'h0000);
        bus.adj = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mode controller and time-keeping core for the stopwatch.
- Sequences RUN / PAUSE / ADJUST operation from debounced button levels and pulses, and owns the MM:SS BCD digit registers.
- Drives a blink-blank mask for the display multiplexer.
- Sits between the debouncer outputs and the 7-segment driver. It consumes one-cycle 1 Hz and 2 Hz strobes from the clock divider.

Parameters:
- START_PAUSED, 0: pause flag value after reset (0 = counting, 1 = paused).
- BLINK_EN, 1: 1 = blank the field being adjusted on alternate 2 Hz strobes; 0 = never blank.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pause_p  in  1  one-cycle pulse from debounced pause button; toggles the pause flag.
- adj  in  1  debounced level; 1 = adjust mode.
- sel  in  1  debounced level; field to adjust: 0 = minutes, 1 = seconds.
- tick_1hz  in  1  one-cycle strobe at 1 Hz.
- tick_2hz  in  1  one-cycle strobe at 2 Hz.
- min1  out  3  minutes tens digit, 0–5.
- min2  out  4  minutes ones digit, 0–9.
- sec1  out  3  seconds tens digit, 0–5.
- sec2  out  4  seconds ones digit, 0–9.
- blank_min  out  1  1 = display must blank the minute digits.
- blank_sec  out  1  1 = display must blank the second digits.
- mode  out  2  current state: 00 RUN, 01 PAUSE, 10 ADJUST.

Behaviour:
- Reset values when reset = 1 at an edge:
  - all digits 0;
  - pause flag = START_PAUSED;
  - blink phase = 0;
  - blank_min = blank_sec = 0;
  - mode = PAUSE if START_PAUSED else RUN.
- Reset overrides every other input in the same cycle, including mid-adjust and mid-carry.
- State decode (registered):
  - ADJUST if adj = 1;
  - else PAUSE if pause flag = 1;
  - else RUN.
  - mode reflects the state one cycle after the input change.
- Pause flag:
  - Toggles on every pause_p, in any state including ADJUST.
  - Leaving ADJUST returns to RUN or PAUSE per the current flag.
- RUN:
  - On tick_1hz, increment MM:SS by one second.
  - Carry chain: sec2 9→0 carries to sec1; sec1 5→0 carries to min2; min2 9→0 carries to min1; min1 5→0.
  - 59:59 wraps to 00:00.
  - tick_2hz is ignored.
- PAUSE: digits hold; both ticks are ignored.
- ADJUST:
  - tick_1hz is ignored.
  - On tick_2hz, increment only the selected field as a 00–59 BCD value (ones 9→0 carries to tens; 59 → 00).
  - No carry between fields; the unselected field holds.
  - sel is sampled in the same cycle as tick_2hz.
- Blink:
  - In ADJUST, the blink phase toggles on each tick_2hz.
  - blank_min = BLINK_EN & ADJUST & ~sel & phase.
  - blank_sec = BLINK_EN & ADJUST & sel & phase.
  - The phase clears to 0 whenever not in ADJUST.
  - Both blank outputs are 0 outside ADJUST.
- Latency:
  - Digit and blank outputs are registered and change on the edge that samples the strobe, i.e. visible the cycle after the strobe is high.
  - Mode change is also 1 cycle.
- Simultaneous events:
  - pause_p with tick_1hz in RUN: the increment is applied (decision uses the state registered before the edge) and the flag toggles on the same edge.
  - adj rising with tick_1hz: the state before the edge governs, so the RUN increment occurs.
  - tick_1hz and tick_2hz together: each is honoured per the rules of the current state.
- Digits are never out of BCD range; no illegal-value recovery is required beyond reset.

Test Plan:
- Reset (START_PAUSED = 0), then 61 tick_1hz strobes → min1:min2:sec1:sec2 = 0:1:0:1; mode = 00.
- Preload 59:59 via ADJUST (sel = 0 and sel = 1, 59 tick_2hz each), release adj, one tick_1hz → 00:00.
- In RUN at 00:10, pause_p, then 5 tick_1hz → 00:10 held, mode = 01; pause_p, 1 tick_1hz → 00:11.
- adj = 1, sel = 1 at 00:58, 3 tick_2hz → 00:01 (no carry into minutes).
  - blank_sec sequence 1, 0, 1 after each strobe; blank_min = 0.
  - Release adj → blank_sec = 0, phase cleared.
- pause_p coincident with tick_1hz in RUN at 00:05 → 00:06 and mode = 01 next cycle.
- Assert reset during ADJUST at 12:34 with tick_2hz high in the same cycle → 00:00, blanks 0, mode = 00.
